fifo_wr_arb: RTL and testbench

Write-side arbiter that shares the write port of the asynchronous FIFO among several requesters in the WCLK domain. Grants are round-robin and packet-based: a granted requester keeps the port until its LAST beat is accepted. The block drives WINC/WDATA into the FIFO write path and honours WFULL from the write-pointer logic, so no beat is ever issued into a full FIFO.

---
 rtl/fifo_wr_arb_if.sv | 25 ++
 rtl/fifo_wr_arb.sv | 131 +++++++++++++
 tb/tb_fifo_wr_arb.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arb_if.sv
// fifo_wr_arb_if: requester-side and FIFO-side signals of the write-port arbiter.
// slave modport is the arbiter's view; master modport is the driving side.
interface fifo_wr_arb_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_SIZE = 8
);
  logic [NUM_REQ-1:0]           REQ;
  logic [NUM_REQ-1:0]           LAST;
  logic [NUM_REQ*DATA_SIZE-1:0] DATA;
  logic                         WFULL;
  logic [NUM_REQ-1:0]           GNT;
  logic                         WINC;
  logic [DATA_SIZE-1:0]         WDATA;
  logic                         BUSY;

  modport master (
    output REQ, LAST, DATA, WFULL,
    input  GNT, WINC, WDATA, BUSY
  );

  modport slave (
    input  REQ, LAST, DATA, WFULL,
    output GNT, WINC, WDATA, BUSY
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin, packet-based arbiter for the async FIFO write port (WCLK domain).
// A grant is held until the granted requester's LAST beat is accepted.
// Optional feature: define WR_ARB_BURST_LIMIT_EN to also release after MAX_BURST beats.
module fifo_wr_arb #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned MAX_BURST = 8
) (
  input logic          WCLK,
  input logic          WRST_n,
  fifo_wr_arb_if.slave bus
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [IdxW-1:0]    prio_q, prio_d;
  logic [IdxW-1:0]    prio_next;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_vld;
  logic [IdxW:0]      cand;
  logic               hold;
  logic               accept;
  logic               burst_done;
  logic               release_gnt;

  assign hold        = (state_q == StHold);
  assign accept      = hold & gnt_q[idx_q] & bus.REQ[idx_q] & ~bus.WFULL;
  assign release_gnt = accept & (bus.LAST[idx_q] | burst_done);
  assign prio_next   = (idx_q == IdxW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

  // Round-robin pick: first set REQ bit searching upward from prio_q, wrapping
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      cand = {1'b0, prio_q} + (IdxW + 1)'(k);
      if (cand >= (IdxW + 1)'(NUM_REQ)) begin
        cand = cand - (IdxW + 1)'(NUM_REQ);
      end
      if (!pick_vld && bus.REQ[cand[IdxW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IdxW-1:0];
      end
    end
  end

`ifdef WR_ARB_BURST_LIMIT_EN
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;

  // Current accepted beat is the MAX_BURST-th of this grant
  assign burst_done = (beat_cnt_q == CntW'(MAX_BURST - 1));

  // Beat counter: counts accepted beats, clears whenever the grant is released
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (release_gnt) begin
      beat_cnt_d = '0;
    end else if (accept) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end

  // Beat counter register
  always_ff @(posedge WCLK or negedge WRST_n) begin
    if (!WRST_n) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end
`else
  logic unused_max_burst;

  assign burst_done       = 1'b0;
  assign unused_max_burst = ^32'(MAX_BURST);
`endif

  // Next-state: grant on any request in idle, release on accepted LAST (or burst limit)
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    prio_d  = prio_q;
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d = StHold;
          idx_d   = pick_idx;
          gnt_d   = NUM_REQ'(1) << pick_idx;
        end
      end
      StHold: begin
        if (release_gnt) begin
          state_d = StIdle;
          gnt_d   = '0;
          prio_d  = prio_next;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, grant and priority registers
  always_ff @(posedge WCLK or negedge WRST_n) begin
    if (!WRST_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      idx_q   <= '0;
      prio_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      prio_q  <= prio_d;
    end
  end

  assign bus.GNT   = gnt_q;
  assign bus.BUSY  = hold;
  assign bus.WINC  = accept;
  assign bus.WDATA = hold ? bus.DATA[int'(idx_q)*DATA_SIZE +: DATA_SIZE] : '0;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed scenarios plus randomized traffic, checked against a
// packet-level reference model of the arbiter.
module tb_fifo_wr_arb;

  localparam int NR = 4;
  localparam int DS = 8;
  localparam int MB = 8;

  logic WCLK;
  logic WRST_n;

  fifo_wr_arb_if #(.NUM_REQ(NR), .DATA_SIZE(DS)) bus ();

  fifo_wr_arb #(
    .NUM_REQ  (NR),
    .DATA_SIZE(DS),
    .MAX_BURST(MB)
  ) dut (
    .WCLK  (WCLK),
    .WRST_n(WRST_n),
    .bus   (bus)
  );

  initial WCLK = 1'b0;
  always #5 WCLK = ~WCLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner of the port (-1 = nobody), round-robin pointer, beats this grant
  int m_owner = -1;
  int m_prio  = 0;
  int m_beats = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [NR-1:0] v);
    int r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_prio  = 0;
    m_beats = 0;
  endtask

  // Compare outputs mid-cycle against the model, advance the model across the next edge.
  // Returns at posedge + 1.
  task automatic tick();
    logic [NR-1:0] exp_gnt;
    logic [DS-1:0] exp_wdata;
    logic          acc;
    logic          limit;
    @(negedge WCLK);
    exp_gnt   = '0;
    exp_wdata = '0;
    acc       = 1'b0;
    if (m_owner >= 0) begin
      exp_gnt   = NR'(1 << m_owner);
      acc       = bus.REQ[m_owner] && !bus.WFULL;
      exp_wdata = bus.DATA[m_owner*DS +: DS];
    end
    check_eq("gnt",   32'(bus.GNT),   32'(exp_gnt));
    check_eq("busy",  32'(bus.BUSY),  32'(m_owner >= 0));
    check_eq("winc",  32'(bus.WINC),  32'(acc));
    check_eq("wdata", 32'(bus.WDATA), 32'(exp_wdata));
    if (m_owner < 0) begin
      for (int k = 0; k < NR; k++) begin
        if (bus.REQ[(m_prio + k) % NR]) begin
          m_owner = (m_prio + k) % NR;
          m_beats = 0;
          break;
        end
      end
    end else if (acc) begin
      m_beats++;
`ifdef WR_ARB_BURST_LIMIT_EN
      limit = (m_beats == MB);
`else
      limit = 1'b0;
`endif
      if (bus.LAST[m_owner] || limit) begin
        m_prio  = (m_owner + 1) % NR;
        m_owner = -1;
      end
    end
    @(posedge WCLK);
    #1;
  endtask

  task automatic do_reset();
    WRST_n    = 1'b0;
    bus.REQ   = '0;
    bus.LAST  = '0;
    bus.DATA  = '0;
    bus.WFULL = 1'b0;
    model_reset();
    repeat (2) @(posedge WCLK);
    @(negedge WCLK);
    WRST_n = 1'b1;
    @(posedge WCLK);
    #1;
  endtask

  initial begin
    int order[$];
    int prev;
    int sent0;

    // Reset state
    WRST_n    = 1'b0;
    bus.REQ   = 4'b0110;
    bus.LAST  = '0;
    bus.DATA  = 32'hDEADBEEF;
    bus.WFULL = 1'b0;
    #3;
    check_eq("rst_gnt",   32'(bus.GNT),   32'h0);
    check_eq("rst_busy",  32'(bus.BUSY),  32'h0);
    check_eq("rst_winc",  32'(bus.WINC),  32'h0);
    check_eq("rst_wdata", 32'(bus.WDATA), 32'h0);
    do_reset();

    // Single request, 3-beat packet from requester 1
    bus.REQ  = 4'b0010;
    bus.DATA = 32'h0000A500;
    tick();
    check_eq("t1_gnt", 32'(bus.GNT), 32'h2);
    for (int i = 0; i < 3; i++) begin
      bus.LAST = (i == 2) ? 4'b0010 : 4'b0000;
      #1;
      check_eq("t1_winc",  32'(bus.WINC),  32'h1);
      check_eq("t1_wdata", 32'(bus.WDATA), 32'hA5);
      tick();
    end
    check_eq("t1_gnt_clr", 32'(bus.GNT), 32'h0);
    bus.REQ  = '0;
    bus.LAST = '0;
    tick();

    // Round-robin fairness with all requesting, 2-beat packets
    do_reset();
    bus.REQ = 4'b1111;
    prev    = 0;
    order   = {};
    for (int c = 0; c < 15; c++) begin
      bus.DATA = $urandom;
      bus.LAST = (m_owner >= 0 && m_beats == 1) ? 4'b1111 : 4'b0000;
      tick();
      if (bus.GNT != 0 && prev == 0) order.push_back(onehot_idx(bus.GNT));
      prev = int'(bus.GNT);
    end
    check_eq("rr_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5 && i < order.size(); i++) begin
      check_eq("rr_order", 32'(order[i]), 32'(i % NR));
    end
    bus.REQ  = '0;
    bus.LAST = '0;
    tick();

    // Backpressure and requester gap on requester 0 while others request
    do_reset();
    bus.REQ = 4'b0001;
    tick();
    for (int c = 0; c < 12; c++) begin
      bus.DATA  = {8'h33, 8'h22, 8'h11, 8'(8'h40 + c)};
      bus.WFULL = (c >= 2 && c < 6);
      bus.REQ   = (c == 7 || c == 8) ? 4'b0110 : 4'b0111;
      bus.LAST  = (c == 11) ? 4'b0001 : 4'b0000;
      #1;
      if (c >= 2 && c < 9 && c != 6) begin
        check_eq("stall_winc", 32'(bus.WINC), 32'h0);
        check_eq("stall_gnt",  32'(bus.GNT),  32'h1);
      end
      tick();
    end
    check_eq("bp_next_gnt", 32'(bus.GNT), 32'h0);
    bus.REQ  = '0;
    bus.LAST = '0;
    tick();

    // Asynchronous reset in the middle of a burst
    bus.REQ = 4'b0100;
    tick();
    tick();
    WRST_n = 1'b0;
    #1;
    check_eq("arst_gnt",  32'(bus.GNT),  32'h0);
    check_eq("arst_winc", 32'(bus.WINC), 32'h0);
    check_eq("arst_busy", 32'(bus.BUSY), 32'h0);
    #2;
    WRST_n = 1'b1;
    model_reset();
    bus.REQ = 4'b1001;
    tick();
    check_eq("arst_prio0", 32'(bus.GNT), 32'h1);
    WRST_n = 1'b0;
    #2;
    WRST_n = 1'b1;
    model_reset();
    bus.REQ = 4'b1000;
    tick();
    check_eq("arst_req3", 32'(bus.GNT), 32'h8);
    bus.REQ = '0;
    tick();

`ifdef WR_ARB_BURST_LIMIT_EN
    // 12-beat packet from requester 0 is split by the burst limit
    do_reset();
    sent0 = 0;
    prev  = 0;
    order = {};
    bus.REQ = 4'b0011;
    for (int c = 0; c < 40 && sent0 < 12; c++) begin
      bus.DATA = $urandom;
      bus.LAST = {3'b001, 1'(sent0 == 11)};
      #1;
      if (bus.WINC && bus.GNT == 4'b0001) sent0++;
      if (bus.WINC && bus.GNT == 4'b0010) bus.REQ[1] = 1'b0;
      tick();
      if (bus.GNT != 0 && prev == 0) order.push_back(onehot_idx(bus.GNT));
      prev = int'(bus.GNT);
    end
    check_eq("bl_sent0", 32'(sent0), 32'd12);
    check_eq("bl_ngrants", 32'(order.size()), 32'd3);
    if (order.size() >= 3) begin
      check_eq("bl_g0", 32'(order[0]), 32'd0);
      check_eq("bl_g1", 32'(order[1]), 32'd1);
      check_eq("bl_g2", 32'(order[2]), 32'd0);
    end
    bus.REQ  = '0;
    bus.LAST = '0;
    tick();
`else
    sent0 = 0;
`endif

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bus.REQ   = NR'($urandom | $urandom);
      bus.LAST  = NR'($urandom & $urandom);
      bus.WFULL = ($urandom_range(0, 3) == 0);
      bus.DATA  = $urandom;
      if (c % 150 == 149) begin
        WRST_n = 1'b0;
        #1;
        check_eq("rnd_arst_gnt", 32'(bus.GNT), 32'h0);
        #1;
        WRST_n = 1'b1;
        model_reset();
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
